ahb_decoder_mux: RTL and testbench
==================================

// Module: ahb_decoder_mux
// PURPOSE
//  AHB-Lite interconnect stage between the single master and all slaves, including the default (unmapped-address) slave.
//  Decodes HADDR into one-hot HSEL. Registers the data-phase owner and muxes HREADYOUT/HRESP/HRDATA back to the master.
//  A stall watchdog converts a hung slave into a spec-compliant two-cycle ERROR.
// PARAMETERS
//  NUM_SLAVES      4             mapped slaves; HSEL index NUM_SLAVES = default slave
//  ADDR_W          32            address width
//  DATA_W          32            data width
//  SLV_BASE        {i*32'h1000_0000}  packed NUM_SLAVES*ADDR_W, slot i = base of slave i
//  SLV_MASK        all 32'hF000_0000  packed NUM_SLAVES*ADDR_W; match = (HADDR & MASK)==BASE
//  TIMEOUT_CYCLES  16            max consecutive stall cycles; 0 disables watchdog
// PORTS
//  HCLK         in   1                 clock
//  HRESETn      in   1                 reset, synchronous, active-low
//  HADDR        in   ADDR_W            master address-phase address
//  HTRANS       in   2                 master transfer type (00 IDLE,01 BUSY,10 NONSEQ,11 SEQ)
//  HSEL         out  NUM_SLAVES+1      one-hot slave select, bit NUM_SLAVES = default slave
//  HREADY       out  1                 muxed ready to master, broadcast to all slaves
//  HRESP        out  2                 muxed response to master
//  HRDATA       out  DATA_W            muxed read data to master
//  S_HREADYOUT  in   NUM_SLAVES+1      per-slave ready-out
//  S_HRESP      in   2*(NUM_SLAVES+1)  per-slave response, slot i at [2i+:2]
//  S_HRDATA     in   DATA_W*(NUM_SLAVES+1)  per-slave read data, slot i at [DATA_W*i+:DATA_W]
//  timeout_err  out  1                 one-cycle pulse when watchdog fires
// BEHAVIOUR
//  Decode (combinational, address phase):
//   - HSEL depends on HADDR only, not HTRANS. Lowest matching index wins on overlap.
//   - No match -> HSEL[NUM_SLAVES]=1. Exactly one HSEL bit is high at all times.
//  Data-phase owner dsel (register, NUM_SLAVES+1 one-hot or NONE):
//   - Updates only on an edge where HREADY==1.
//   - HTRANS is NONSEQ or SEQ -> dsel<=HSEL; IDLE or BUSY -> dsel<=NONE.
//  FSM states: IDLE (dsel=NONE), DATA, TO_ERR1, TO_ERR2.
//   - IDLE:    HREADY=1, HRESP=00, HRDATA=0. Enters DATA on capture of a valid transfer.
//   - DATA:    HREADY/HRESP/HRDATA = S_* slot of dsel, passed through unchanged (incl. slave ERROR 01 and 10/11).
//              stall_cnt (width $clog2(TIMEOUT_CYCLES+1)) increments each cycle with selected S_HREADYOUT=0;
//              it clears when S_HREADYOUT=1.
//              If stall_cnt==TIMEOUT_CYCLES-1 and S_HREADYOUT=0 -> TO_ERR1 (i.e. after TIMEOUT_CYCLES stall cycles).
//              If S_HREADYOUT=1 in that same cycle, normal completion wins.
//              On completion, next state follows the dsel capture rule (IDLE or DATA).
//   - TO_ERR1: HREADY=0, HRESP=01, HRDATA=0, timeout_err=1. Always -> TO_ERR2.
//   - TO_ERR2: HREADY=1, HRESP=01, HRDATA=0. dsel captured per normal rule; -> IDLE or DATA; stall_cnt<=0.
//   - Slave inputs are ignored in TO_ERR1/TO_ERR2.
//  TIMEOUT_CYCLES==0: watchdog never fires; TO_ERR states are unreachable.
//  Reset (HRESETn=0 at an edge, any state, incl. mid-transfer or mid-error):
//   - state=IDLE, dsel=NONE, stall_cnt=0, timeout_err=0.
//   - Outputs HREADY=1, HRESP=00, HRDATA=0 from that edge. HSEL stays combinational.
//  Latency: zero added cycles; response is muxed in the same cycle the slave drives it.
// TESTING
//  1. Write/read slave 1: HADDR=0x1000_0040 NONSEQ -> HSEL=5'b00010.
//     Next cycle HRDATA=S_HRDATA[1]=0xDEAD_BEEF, HRESP=00.
//  2. Unmapped: HADDR=0x8000_0000 NONSEQ -> HSEL=5'b10000.
//     Default slave ERROR 01 appears on HRESP in the data phase.
//  3. Back-to-back: NONSEQ slave0 then SEQ slave2, slave0 holds 3 wait states.
//     -> HREADY=0 for 3 cycles; dsel switches to slave2 only on the edge HREADY=1.
//  4. Hang: slave3 holds HREADYOUT=0 forever.
//     -> after 16 stall cycles: HREADY=0/HRESP=01 with timeout_err=1, then HREADY=1/HRESP=01, then IDLE.
//  5. Race: slave3 raises HREADYOUT in the 16th stall cycle -> OKAY completion, no timeout_err.
//  6. Reset asserted during TO_ERR1 -> next edge HREADY=1, HRESP=00, HRDATA=0, timeout_err=0.

Source files
------------

// File: rtl/ahb_decoder_mux.sv
// Purpose : AHB-Lite decode/response-mux stage (one master, NUM_SLAVES slaves + default slave) with stall watchdog.
// Latency : zero added cycles; HSEL is combinational from HADDR and the response is muxed in the cycle the slave drives it.
// Backpressure: HREADY follows the data-phase owner's HREADYOUT; a hang longer than TIMEOUT_CYCLES becomes a two-cycle ERROR.
//
// Ports:
//   HCLK, HRESETn               clock, synchronous active-low reset
//   HADDR, HTRANS               master address phase
//   HSEL                        one-hot slave select, bit NUM_SLAVES = default (unmapped) slave
//   HREADY, HRESP, HRDATA       muxed response to the master (HREADY also broadcast to slaves)
//   S_HREADYOUT/S_HRESP/S_HRDATA per-slave responses, slot i at [i], [2i+:2], [DATA_W*i+:DATA_W]
//   timeout_err                 one-cycle pulse in the first ERROR cycle of a watchdog abort
module ahb_decoder_mux #(
  parameter int                          NUM_SLAVES     = 4,
  parameter int                          ADDR_W         = 32,
  parameter int                          DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE      = {32'h3000_0000, 32'h2000_0000,
                                                           32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK      = {4{32'hF000_0000}},
  parameter int                          TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [ADDR_W-1:0]                HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [NUM_SLAVES:0]              HSEL,
  output logic                             HREADY,
  output logic [1:0]                       HRESP,
  output logic [DATA_W-1:0]                HRDATA,
  input  logic [NUM_SLAVES:0]              S_HREADYOUT,
  input  logic [2*(NUM_SLAVES+1)-1:0]      S_HRESP,
  input  logic [DATA_W*(NUM_SLAVES+1)-1:0] S_HRDATA,
  output logic                             timeout_err
);

  localparam int NS    = NUM_SLAVES + 1;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic [1:0]       state_q, state_d;
  // dsel is only meaningful in ST_DATA; "no owner" is carried by the state itself
  logic [IDX_W-1:0] dsel_q, dsel_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [IDX_W-1:0]  hsel_idx;
  logic              hit;
  logic              xfer_vld;
  logic              capture;
  logic              sel_rdy;
  logic [1:0]        sel_resp;
  logic [DATA_W-1:0] sel_data;

  // Address decode: scan upward so the lowest matching slave wins on overlap.
  always_comb begin
    hsel_idx = IDX_W'(NUM_SLAVES);
    hit      = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hsel_idx = IDX_W'(i);
        hit      = 1'b1;
      end
    end
  end

  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NS; i++) begin
      HSEL[i] = (hsel_idx == IDX_W'(i));
    end
  end

  assign xfer_vld = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // Response slot of the current data-phase owner.
  always_comb begin
    sel_rdy  = 1'b1;
    sel_resp = RESP_OKAY;
    sel_data = '0;
    for (int i = 0; i < NS; i++) begin
      if (dsel_q == IDX_W'(i)) begin
        sel_rdy  = S_HREADYOUT[i];
        sel_resp = S_HRESP[2*i +: 2];
        sel_data = S_HRDATA[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dsel_d      = dsel_q;
    stall_cnt_d = stall_cnt_q;
    HREADY      = 1'b1;
    HRESP       = RESP_OKAY;
    HRDATA      = '0;
    timeout_err = 1'b0;
    capture     = 1'b0;

    case (state_q)
      ST_IDLE: capture = 1'b1;
      ST_DATA: begin
        HREADY = sel_rdy;
        HRESP  = sel_resp;
        HRDATA = sel_data;
        if (sel_rdy) begin
          // completion takes priority over a watchdog expiring in the same cycle
          capture     = 1'b1;
          stall_cnt_d = '0;
        end else if (WDOG_EN && (stall_cnt_q == STALL_LIM)) begin
          state_d     = ST_ERR1;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      ST_ERR1: begin
        HREADY      = 1'b0;
        HRESP       = RESP_ERROR;
        timeout_err = 1'b1;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP       = RESP_ERROR;
        capture     = 1'b1;
        stall_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // HREADY is high whenever capture is set, so this is the AHB data-phase handover.
    if (capture) begin
      if (xfer_vld) begin
        state_d = ST_DATA;
        dsel_d  = hsel_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      dsel_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dsel_q      <= dsel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
module tb_ahb_decoder_mux;
  localparam int NS = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [4:0]   hsel;
  logic         hready;
  logic [1:0]   hresp;
  logic [31:0]  hrdata;
  logic [4:0]   s_rdy;
  logic [9:0]   s_resp;
  logic [159:0] s_data;
  logic         to_err;

  always #5 clk = ~clk;

  ahb_decoder_mux dut (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(htrans),
    .HSEL(hsel), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
    .S_HREADYOUT(s_rdy), .S_HRESP(s_resp), .S_HRDATA(s_data),
    .timeout_err(to_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Default memory map: slave i owns the 256 MB window starting at i*0x1000_0000.
  function automatic int decode(input logic [31:0] a);
    int top;
    top = int'(a[31:28]);
    return (top < NS) ? top : NS;
  endfunction

  // Reference model: who owns the data phase, how long it has stalled,
  // and which cycle of a watchdog ERROR we are in (0 = none).
  int m_owner  = -1;
  int m_stall  = 0;
  int m_err    = 0;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner  = -1;
      m_stall  = 0;
      m_err    = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (m_err == 1) begin
        m_err = 2;
      end else if (m_err == 2 || m_owner < 0 || s_rdy[m_owner]) begin
        m_err   = 0;
        m_stall = 0;
        m_owner = htrans[1] ? decode(haddr) : -1;
      end else begin
        m_stall++;
        if (TO > 0 && m_stall == TO) begin
          m_err   = 1;
          m_stall = 0;
        end
      end
    end
  end

  logic [4:0]  e_hsel;
  logic        e_rdy;
  logic [1:0]  e_resp;
  logic [31:0] e_data;
  logic        e_to;

  always @(negedge clk) begin
    if (model_ok) begin
      e_hsel = '0;
      e_hsel[decode(haddr)] = 1'b1;
      e_rdy = 1'b1; e_resp = 2'b00; e_data = '0; e_to = 1'b0;
      if (m_err == 1) begin
        e_rdy = 1'b0; e_resp = 2'b01; e_to = 1'b1;
      end else if (m_err == 2) begin
        e_resp = 2'b01;
      end else if (m_owner >= 0) begin
        e_rdy  = s_rdy[m_owner];
        e_resp = s_resp[2*m_owner +: 2];
        e_data = s_data[32*m_owner +: 32];
      end
      check("m_hsel",   32'(hsel),   32'(e_hsel));
      check("m_hready", 32'(hready), 32'(e_rdy));
      check("m_hresp",  32'(hresp),  32'(e_resp));
      check("m_hrdata", hrdata,      e_data);
      check("m_tmo",    32'(to_err), 32'(e_to));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic rdy, input logic [1:0] resp, input logic [31:0] d);
    s_rdy[i]          = rdy;
    s_resp[2*i +: 2]  = resp;
    s_data[32*i +: 32] = d;
  endtask

  // Start a transfer to slave 3 and let it stall through the full watchdog window;
  // returns positioned in the first ERROR cycle.
  task automatic hang_slave3();
    haddr = 32'h3000_0000; htrans = 2'b10;
    set_slot(3, 1'b1, 2'b00, 32'h3333_3333);
    step();
    htrans = 2'b00; haddr = 32'h0; s_rdy[3] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check("hang_stall_rdy", 32'(hready), 32'd0);
      check("hang_stall_tmo", 32'(to_err), 32'd0);
      step();
    end
  endtask

  int hang_left = 0;

  initial begin
    rst_n = 1'b0; haddr = '0; htrans = 2'b00;
    s_rdy = '1; s_resp = '0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hresp",  32'(hresp),  32'd0);
    check("rst_hrdata", hrdata,      32'd0);
    check("rst_tmo",    32'(to_err), 32'd0);
    step();

    // 1: read slave 1
    rst_n = 1'b1; haddr = 32'h1000_0040; htrans = 2'b10;
    set_slot(1, 1'b1, 2'b00, 32'hDEAD_BEEF);
    @(negedge clk); check("t1_hsel", 32'(hsel), 32'h02);
    step(); htrans = 2'b00; haddr = 32'h0;
    @(negedge clk);
    check("t1_hrdata", hrdata, 32'hDEAD_BEEF);
    check("t1_hresp", 32'(hresp), 32'd0);
    check("t1_hready", 32'(hready), 32'd1);

    // 2: unmapped address -> default slave two-cycle ERROR
    step(); haddr = 32'h8000_0000; htrans = 2'b10;
    @(negedge clk); check("t2_hsel", 32'(hsel), 32'h10);
    step(); htrans = 2'b00; haddr = 32'h0; set_slot(4, 1'b0, 2'b01, 32'h0);
    @(negedge clk);
    check("t2_err1_resp", 32'(hresp), 32'd1);
    check("t2_err1_rdy", 32'(hready), 32'd0);
    step(); set_slot(4, 1'b1, 2'b01, 32'h0);
    @(negedge clk);
    check("t2_err2_resp", 32'(hresp), 32'd1);
    check("t2_err2_rdy", 32'(hready), 32'd1);
    step(); set_slot(4, 1'b1, 2'b00, 32'h0);

    // 3: slave 0 with 3 wait states, pipelined SEQ to slave 2
    haddr = 32'h0000_0010; htrans = 2'b10;
    set_slot(0, 1'b1, 2'b00, 32'h0000_AAAA);
    set_slot(2, 1'b1, 2'b00, 32'h2222_0000);
    step(); haddr = 32'h2000_0000; htrans = 2'b11; s_rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_wait_rdy", 32'(hready), 32'd0);
      check("t3_wait_dat", hrdata, 32'h0000_AAAA);
      step();
    end
    s_rdy[0] = 1'b1;
    @(negedge clk);
    check("t3_done_rdy", 32'(hready), 32'd1);
    check("t3_done_dat", hrdata, 32'h0000_AAAA);
    step(); htrans = 2'b00; haddr = 32'h0;
    @(negedge clk);
    check("t3_s2_dat", hrdata, 32'h2222_0000);
    step();

    // 4: hung slave -> watchdog ERROR sequence
    hang_slave3();
    @(negedge clk);
    check("t4_err1_rdy", 32'(hready), 32'd0);
    check("t4_err1_resp", 32'(hresp), 32'd1);
    check("t4_err1_tmo", 32'(to_err), 32'd1);
    check("t4_err1_dat", hrdata, 32'd0);
    step();
    @(negedge clk);
    check("t4_err2_rdy", 32'(hready), 32'd1);
    check("t4_err2_resp", 32'(hresp), 32'd1);
    check("t4_err2_tmo", 32'(to_err), 32'd0);
    step();
    @(negedge clk);
    check("t4_idle_resp", 32'(hresp), 32'd0);
    check("t4_idle_rdy", 32'(hready), 32'd1);
    step(); s_rdy[3] = 1'b1;

    // 5: ready arrives in the 16th stall cycle -> normal completion
    haddr = 32'h3000_0000; htrans = 2'b10;
    step(); htrans = 2'b00; haddr = 32'h0; s_rdy[3] = 1'b0;
    repeat (TO - 1) step();
    s_rdy[3] = 1'b1;
    @(negedge clk);
    check("t5_rdy", 32'(hready), 32'd1);
    check("t5_resp", 32'(hresp), 32'd0);
    check("t5_tmo", 32'(to_err), 32'd0);
    step();
    @(negedge clk); check("t5_after_tmo", 32'(to_err), 32'd0);
    step();

    // 6: reset during the first ERROR cycle, with a new transfer being offered
    hang_slave3();
    @(negedge clk);
    check("t6_err1_tmo", 32'(to_err), 32'd1);
    rst_n = 1'b0; haddr = 32'h3000_0000; htrans = 2'b10;
    step();
    @(negedge clk);
    check("t6_rst_rdy", 32'(hready), 32'd1);
    check("t6_rst_resp", 32'(hresp), 32'd0);
    check("t6_rst_dat", hrdata, 32'd0);
    check("t6_rst_tmo", 32'(to_err), 32'd0);
    step(); rst_n = 1'b1; htrans = 2'b00; s_rdy[3] = 1'b1;

    // Random traffic with occasional hung-slave bursts and resets
    for (int c = 0; c < 3000; c++) begin
      step();
      if (hang_left > 0) hang_left--;
      else if ($urandom_range(0, 99) < 2) hang_left = 20;
      haddr  = $urandom;
      htrans = 2'($urandom_range(0, 3));
      for (int i = 0; i < 5; i++) begin
        s_rdy[i] = (hang_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        s_data[32*i +: 32] = $urandom;
      end
      s_resp = 10'($urandom);
      rst_n  = ($urandom_range(0, 199) != 0);
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
